// File: rtl/sap1_pkg.sv
// sap1_pkg: constants shared by the SAP-1 memory-side blocks (RAM, MAR, PC,
// ram_loader). It holds the default bus widths, the active-low enable levels
// and the ram_loader state encoding.
package sap1_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  // Memory control pins are active low.
  localparam logic CE_ON = 1'b0;
  localparam logic WE_ON = 1'b0;

  // ram_loader state encoding. The values are kept fixed so they read the
  // same in older netlists and waveform viewers.
  typedef logic [2:0] loader_state_t;
  localparam loader_state_t ST_IDLE      = 3'd0;
  localparam loader_state_t ST_WAIT_BYTE = 3'd1;
  localparam loader_state_t ST_SETUP     = 3'd2;
  localparam loader_state_t ST_STROBE    = 3'd3;
  localparam loader_state_t ST_VERIFY    = 3'd4;
  localparam loader_state_t ST_DONE      = 3'd5;

  // True in the states where the RAM must be chip-enabled.
  function automatic logic ce_active(input loader_state_t st);
    return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_VERIFY);
  endfunction

  // True in the states that count as a load in progress.
  function automatic logic busy_state(input loader_state_t st);
    return (st == ST_WAIT_BYTE) || ce_active(st);
  endfunction

endpackage

// File: rtl/ram_loader_addr_ctr.sv
// ram_loader_addr_ctr: loadable address counter for the RAM loader.
// - load sets the counter to START_ADDR.
// - inc advances it by one.
// - last flags that the counter equals LAST_ADDR, using an unsigned compare
//   ADDR_W bits wide.
// The counter saturates at LAST_ADDR and never wraps.
module ram_loader_addr_ctr #(
  parameter int ADDR_W     = 4,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  // Elaboration-time range check. It adds no hardware.
  if (START_ADDR > LAST_ADDR) begin : g_bad_range
    $error("ram_loader_addr_ctr: START_ADDR must not exceed LAST_ADDR");
  end

  logic [ADDR_W-1:0] addr_reg;

  assign addr = addr_reg;
  assign last = (addr_reg == LAST_A);

  // Address register. Load takes priority over increment, and the counter
  // does not advance past the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= START_A;
    end else if (load) begin
      addr_reg <= START_A;
    end else if (inc && !last) begin
      addr_reg <= addr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// ram_loader: sequential writer for the SAP-1 16x8 program/data memory.
// It accepts bytes over a valid/ready handshake and writes them to
// consecutive addresses. Each write is a SETUP cycle (ce_n low) followed by
// a STROBE cycle (ce_n and we_n low).
// Optional build macro RAM_LOADER_VERIFY_EN adds a readback VERIFY cycle
// after each strobe. A readback mismatch sets a sticky err flag.
module ram_loader #(
  parameter int DATA_W     = sap1_pkg::DATA_W,
  parameter int ADDR_W     = sap1_pkg::ADDR_W,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              ce_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import sap1_pkg::*;

  loader_state_t     state_reg, state_next;
  logic [DATA_W-1:0] wdata_reg;
  logic              ce_n_reg, we_n_reg;
  logic              addr_load, addr_inc, addr_last;
  logic              capture, err_clr, err_set;

  ram_loader_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (addr_load),
    .inc  (addr_inc),
    .addr (addr),
    .last (addr_last)
  );

  // Next-state logic. abort outranks everything except reset. An abort
  // during a write still lets that write complete.
  always_comb begin
    state_next = state_reg;
    addr_load  = 1'b0;
    addr_inc   = 1'b0;
    capture    = 1'b0;
    err_clr    = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          // abort alone leaves DONE latched. abort together with start
          // drops back to IDLE.
          if (start || state_reg == ST_IDLE) state_next = ST_IDLE;
        end else if (start) begin
          state_next = ST_WAIT_BYTE;
          addr_load  = 1'b1;
          err_clr    = 1'b1;
        end
      end
      ST_WAIT_BYTE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (byte_valid) begin
          capture    = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = abort ? ST_IDLE : ST_STROBE;
      end
`ifdef RAM_LOADER_VERIFY_EN
      ST_STROBE: begin
        state_next = abort ? ST_IDLE : ST_VERIFY;
      end
      ST_VERIFY: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          err_set = (rdata != wdata_reg);
          if (addr_last) begin
            state_next = ST_DONE;
          end else begin
            addr_inc   = 1'b1;
            state_next = ST_WAIT_BYTE;
          end
        end
      end
`else
      ST_STROBE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (addr_last) begin
          state_next = ST_DONE;
        end else begin
          addr_inc   = 1'b1;
          state_next = ST_WAIT_BYTE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Write-data capture on an accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wdata_reg <= '0;
    else if (capture) wdata_reg <= byte_in;
  end

  // Memory strobes are registered from the next state so that ce_n and we_n
  // come straight from flops and cannot glitch. Asynchronous reset releases
  // them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_reg <= ~CE_ON;
      we_n_reg <= ~WE_ON;
    end else begin
      ce_n_reg <= ce_active(state_next) ? CE_ON : ~CE_ON;
      we_n_reg <= (state_next == ST_STROBE) ? WE_ON : ~WE_ON;
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  logic err_reg;

  // Sticky verify-mismatch flag. It is cleared by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_reg <= 1'b0;
    else if (err_clr) err_reg <= 1'b0;
    else if (err_set) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  // Without readback, rdata and the verify controls have no load.
  logic unused_verify;
  assign unused_verify = ^{rdata, err_clr, err_set};
  assign err = 1'b0;
`endif

  assign ce_n       = ce_n_reg;
  assign we_n       = we_n_reg;
  assign wdata      = wdata_reg;
  assign byte_ready = (state_reg == ST_WAIT_BYTE) && !abort;
  assign busy       = busy_state(state_reg);
  assign done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: self-checking bench for ram_loader, with a behavioural RAM
// and a write monitor. Build with RAM_LOADER_VERIFY_EN defined to exercise
// the readback variant.
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
  localparam int RATE = 4;
  localparam bit VFY  = 1'b1;
`else
  localparam int RATE = 3;
  localparam bit VFY  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [7:0] rdata;
  logic       ce_n, we_n;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_fail = 0;

  ram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .rdata(rdata), .ce_n(ce_n), .we_n(we_n), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM. It writes on an edge where ce_n and we_n are both low,
  // and its readback can be forced to 0xFF at address 3.
  logic [7:0] ram [16];
  logic       corrupt3 = 1'b0;
  assign rdata = (corrupt3 && addr == 4'd3) ? 8'hFF : ram[addr];

  int       cyc = 0;
  int       strobe_count = 0;
  int       shape_bad = 0;
  int       strobe_addrs[$];
  logic       prev_ce = 1'b1, prev_we = 1'b1;
  logic [3:0] prev_addr = 4'd0;

  // Write monitor. Every strobe must follow exactly one setup cycle at the
  // same address; two strobes in a row count as a bad shape.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && ce_n === 1'b0 && we_n === 1'b0) begin
      ram[addr] <= wdata;
      strobe_count <= strobe_count + 1;
      strobe_addrs.push_back(int'(addr));
      if (!(prev_ce === 1'b0 && prev_we === 1'b1 && prev_addr === addr))
        shape_bad <= shape_bad + 1;
    end
    prev_ce   <= ce_n;
    prev_we   <= we_n;
    prev_addr <= addr;
  end

  logic [7:0] exp_mem [16];
  logic [7:0] bytes_q [16];

  task automatic fill_sentinel();
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 8'($urandom);
      exp_mem[i] = ram[i];
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte. Return once the handshake edge has passed, at #1 after
  // that edge.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int w = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (byte_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
      acc_cyc = -1;
    end else begin
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({ce_n, we_n, addr, wdata, byte_ready, busy, done, err} !== {1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: ce_n=%b we_n=%b addr=%0d wdata=%h rdy=%b busy=%b done=%b err=%b required 1 1 0 00 0 0 0 0",
               ce_n, we_n, addr, wdata, byte_ready, busy, done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b byte_ready=%b required 0 0", busy, byte_ready);
    end
  endtask

  task automatic test_stream();
    int acc[16];
    int sc0, bad;
    fill_sentinel();
    for (int i = 0; i < 16; i++) begin
      bytes_q[i] = 8'(8'h09 + 8'(8'h11 * i));
      exp_mem[i] = bytes_q[i];
    end
    sc0 = strobe_count;
    strobe_addrs.delete();
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || addr !== 4'd0) begin
      n_fail++;
      $display("FAIL stream_start: busy=%b addr=%0d required 1 0", busy, addr);
    end
    for (int i = 0; i < 16; i++) send_byte(bytes_q[i], acc[i]);
    byte_valid = 1'b0;
    bad = 0;
    for (int i = 1; i < 16; i++) if (acc[i] - acc[i-1] != RATE) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stream_rate: %0d gaps differ, required all = %0d cycles", bad, RATE);
    end
    repeat (RATE) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_done: done=%b busy=%b required 1 0", done, busy);
    end
    n_cmp++;
    if (strobe_count - sc0 != 16) begin
      n_fail++;
      $display("FAIL stream_strobes: got %0d required 16", strobe_count - sc0);
    end
    bad = 0;
    for (int i = 0; i < strobe_addrs.size(); i++) if (strobe_addrs[i] != i) bad++;
    n_cmp++;
    if (bad != 0 || shape_bad != 0) begin
      n_fail++;
      $display("FAIL stream_order: %0d out-of-order, shape_bad=%0d required 0 0", bad, shape_bad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== exp_mem[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stream_ram: %0d words wrong required 0", bad);
    end
  endtask

  task automatic test_gapped();
    int a, k, sc0, bad;
    fill_sentinel();
    sc0 = strobe_count;
    do_start();
    for (int i = 0; i < 16; i++) begin
      bytes_q[i] = 8'($urandom);
      exp_mem[i] = bytes_q[i];
      send_byte(bytes_q[i], a);
      byte_valid = 1'b0;
      if (i < 15) begin
        k = 0;
        while (k < 10) begin
          @(negedge clk);
          k++;
          if (byte_ready === 1'b1) break;
        end
        n_cmp++;
        if (k != RATE) begin
          n_fail++;
          $display("FAIL gapped_ready_delay: byte %0d ready after %0d required %0d", i, k, RATE);
        end
        repeat (7 - k) @(negedge clk);
      end
    end
    repeat (RATE) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || strobe_count - sc0 != 16) begin
      n_fail++;
      $display("FAIL gapped_done: done=%b strobes=%0d required 1 16", done, strobe_count - sc0);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== exp_mem[i]) bad++;
    n_cmp++;
    if (bad != 0 || shape_bad != 0) begin
      n_fail++;
      $display("FAIL gapped_ram: %0d words wrong, shape_bad=%0d required 0 0", bad, shape_bad);
    end
  endtask

  task automatic test_abort();
    int a, bad;
    fill_sentinel();
    do_start();
    for (int i = 0; i < 6; i++) begin
      bytes_q[i] = 8'($urandom);
      exp_mem[i] = bytes_q[i];
      send_byte(bytes_q[i], a);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (we_n !== 1'b0 || addr !== 4'd5) begin
      n_fail++;
      $display("FAIL abort_in_strobe: we_n=%b addr=%0d required 0 5", we_n, addr);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({we_n, ce_n, busy, done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL abort_outputs: we_n=%b ce_n=%b busy=%b done=%b required 1 1 0 0", we_n, ce_n, busy, done);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== exp_mem[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_ram: %0d words wrong required 0", bad);
    end
    do_start();
    n_cmp++;
    if (addr !== 4'd0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: addr=%0d busy=%b rdy=%b required 0 1 1", addr, busy, byte_ready);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_strobe();
    int a;
    do_start();
    send_byte(8'($urandom), a);
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre_strobe: we_n=%b required 0", we_n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ce_n, we_n, addr, wdata, byte_ready, busy, done, err} !== {1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_strobe: ce_n=%b we_n=%b addr=%0d wdata=%h rdy=%b busy=%b done=%b err=%b required reset values",
               ce_n, we_n, addr, wdata, byte_ready, busy, done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore();
    int a, sc0, bad;
    fill_sentinel();
    do_start();
    for (int i = 0; i < 16; i++) begin
      bytes_q[i] = 8'($urandom);
      exp_mem[i] = bytes_q[i];
      send_byte(bytes_q[i], a);
      if (i == 7) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    repeat (RATE) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== exp_mem[i]) bad++;
    n_cmp++;
    if (bad != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_busy_start: %0d words wrong done=%b required 0 1", bad, done);
    end
    sc0 = strobe_count;
    byte_in = 8'($urandom);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (strobe_count != sc0 || done !== 1'b1 || byte_ready !== 1'b0 || addr !== 4'd15) begin
      n_fail++;
      $display("FAIL ignore_done_valid: strobes=%0d done=%b rdy=%b addr=%0d required 0 1 0 15",
               strobe_count - sc0, done, byte_ready, addr);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_verify();
    int a;
    logic exp_err;
    fill_sentinel();
    corrupt3 = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) begin
      bytes_q[i] = (i == 3) ? 8'h2C : 8'($urandom_range(0, 254));
      send_byte(bytes_q[i], a);
      repeat (RATE) @(negedge clk);
      exp_err = VFY && (i >= 3);
      n_cmp++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL verify_err: after byte %0d err=%b required %b", i, err, exp_err);
      end
    end
    byte_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || ram[3] !== 8'h2C) begin
      n_fail++;
      $display("FAIL verify_done: done=%b ram3=%h required 1 2c", done, ram[3]);
    end
    corrupt3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gapped();
    test_abort();
    test_reset_mid_strobe();
    test_ignore();
    test_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
